// File: rtl/ad_ip_jesd204_tpl_up_bus_mux.sv
// Up-bus fan-out/fan-in with per-direction tracking FSMs and error status.
// Optional ack timeout enabled by defining UP_BUS_TIMEOUT_EN.
module ad_ip_jesd204_tpl_up_bus_mux #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_RDATA = 32'hDEADDEAD
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             up_wreq,
  input  logic [ADDR_WIDTH-1:0]            up_waddr,
  input  logic [DATA_WIDTH-1:0]            up_wdata,
  output logic                             up_wack,
  input  logic                             up_rreq,
  input  logic [ADDR_WIDTH-1:0]            up_raddr,
  output logic [DATA_WIDTH-1:0]            up_rdata,
  output logic                             up_rack,
  output logic                             s_wreq,
  output logic [ADDR_WIDTH-1:0]            s_waddr,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  input  logic [NUM_SLAVES-1:0]            s_wack,
  output logic                             s_rreq,
  output logic [ADDR_WIDTH-1:0]            s_raddr,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]            s_rack,
  input  logic                             err_clr,
  output logic                             err_multi_ack,
  output logic                             err_overrun,
  output logic [15:0]                      err_timeout_cnt,
  output logic                             busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} st_t;

  st_t                   wst_q, rst_q;
  logic                  s_wreq_q, s_rreq_q;
  logic [ADDR_WIDTH-1:0] waddr_q, raddr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic                  wack_q, rack_q;
  logic                  multi_q, ovr_q;
  logic                  multi_d, ovr_d;

  logic                  w_hit, r_hit, w_to, r_to;
  logic [DATA_WIDTH-1:0] rd_merge, rd_resp;

  always_comb begin
    rd_merge = '0;
    for (int n = 0; n < NUM_SLAVES; n++)
      rd_merge |= s_rdata[n*DATA_WIDTH+:DATA_WIDTH] & {DATA_WIDTH{s_rack[n]}};
  end

  assign w_hit = (wst_q == WAIT) && (|s_wack);
  assign r_hit = (rst_q == WAIT) && (|s_rack);

`ifdef UP_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CLAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wcnt_q, rcnt_q;
  logic [15:0]   tcnt_q, tcnt_d;
  logic [15:0]   tbase;
  logic [16:0]   tsum;

  // an ack in the last WAIT cycle takes priority over the timeout
  assign w_to = (wst_q == WAIT) && !(|s_wack) && (wcnt_q == CLAST);
  assign r_to = (rst_q == WAIT) && !(|s_rack) && (rcnt_q == CLAST);
  assign rd_resp = r_hit ? rd_merge : TIMEOUT_RDATA;

  always_comb begin
    tbase  = err_clr ? 16'h0 : tcnt_q;
    tsum   = {1'b0, tbase} + {16'h0, w_to} + {16'h0, r_to};
    tcnt_d = tsum[16] ? 16'hFFFF : tsum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q <= '0;
      rcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
      wcnt_q <= (wst_q == WAIT) ? wcnt_q + 1'b1 : '0;
      rcnt_q <= (rst_q == WAIT) ? rcnt_q + 1'b1 : '0;
    end
  end

  assign err_timeout_cnt = tcnt_q;
`else
  assign w_to = 1'b0;
  assign r_to = 1'b0;
  assign rd_resp = rd_merge;
  assign err_timeout_cnt = 16'h0;
`endif

  always_comb begin
    multi_d = err_clr ? 1'b0 : multi_q;
    ovr_d   = err_clr ? 1'b0 : ovr_q;
    if (((wst_q == WAIT) && ($countones(s_wack) > 1)) ||
        ((rst_q == WAIT) && ($countones(s_rack) > 1)))
      multi_d = 1'b1;
    if ((up_wreq && (wst_q != IDLE)) || (up_rreq && (rst_q != IDLE)))
      ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wst_q    <= IDLE;
      s_wreq_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wack_q   <= 1'b0;
    end else begin
      s_wreq_q <= 1'b0;
      wack_q   <= 1'b0;
      unique case (wst_q)
        IDLE: if (up_wreq) begin
          waddr_q  <= up_waddr;
          wdata_q  <= up_wdata;
          s_wreq_q <= 1'b1;
          wst_q    <= WAIT;
        end
        WAIT: if (w_hit || w_to) begin
          wack_q <= 1'b1;
          wst_q  <= RESP;
        end
        default: wst_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_q    <= IDLE;
      s_rreq_q <= 1'b0;
      raddr_q  <= '0;
      rdata_q  <= '0;
      rack_q   <= 1'b0;
    end else begin
      s_rreq_q <= 1'b0;
      rack_q   <= 1'b0;
      rdata_q  <= '0;
      unique case (rst_q)
        IDLE: if (up_rreq) begin
          raddr_q  <= up_raddr;
          s_rreq_q <= 1'b1;
          rst_q    <= WAIT;
        end
        WAIT: if (r_hit || r_to) begin
          rack_q  <= 1'b1;
          rdata_q <= rd_resp;
          rst_q   <= RESP;
        end
        default: rst_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      multi_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      multi_q <= multi_d;
      ovr_q   <= ovr_d;
    end
  end

  assign s_wreq        = s_wreq_q;
  assign s_waddr       = waddr_q;
  assign s_wdata       = wdata_q;
  assign up_wack       = wack_q;
  assign s_rreq        = s_rreq_q;
  assign s_raddr       = raddr_q;
  assign up_rack       = rack_q;
  assign up_rdata      = rdata_q;
  assign err_multi_ack = multi_q;
  assign err_overrun   = ovr_q;
  assign busy          = (wst_q != IDLE) || (rst_q != IDLE);

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_up_bus_mux.sv
// Randomized bench for ad_ip_jesd204_tpl_up_bus_mux against a transaction model.
// Define UP_BUS_TIMEOUT_EN to also cover the ack timeout (TIMEOUT_CYCLES=8).
module tb_ad_ip_jesd204_tpl_up_bus_mux;
  localparam int NS = 4;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic up_wreq = 0, up_rreq = 0, err_clr = 0;
  logic [AW-1:0] up_waddr = '0, up_raddr = '0;
  logic [DW-1:0] up_wdata = '0;
  logic up_wack, up_rack, s_wreq, s_rreq;
  logic [DW-1:0] up_rdata, s_wdata;
  logic [AW-1:0] s_waddr, s_raddr;
  logic [NS-1:0] s_wack = '0, s_rack = '0;
  logic [NS*DW-1:0] s_rdata = '0;
  logic err_multi_ack, err_overrun, busy;
  logic [15:0] err_timeout_cnt;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sd [NS];
  bit exp_multi = 0, exp_ovr = 0;
  int exp_cnt = 0;

  ad_ip_jesd204_tpl_up_bus_mux #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO), .TIMEOUT_RDATA(32'hDEADDEAD)
  ) dut (
    .clk(clk), .reset(reset),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata),
    .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata),
    .up_rack(up_rack),
    .s_wreq(s_wreq), .s_waddr(s_waddr), .s_wdata(s_wdata),
    .s_wack(s_wack),
    .s_rreq(s_rreq), .s_raddr(s_raddr), .s_rdata(s_rdata),
    .s_rack(s_rack),
    .err_clr(err_clr), .err_multi_ack(err_multi_ack),
    .err_overrun(err_overrun), .err_timeout_cnt(err_timeout_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_sd();
    for (int n = 0; n < NS; n++) begin
      sd[n] = $urandom;
      s_rdata[n*DW+:DW] = sd[n];
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [NS-1:0] m);
    logic [DW-1:0] r = '0;
    for (int n = 0; n < NS; n++) if (m[n]) r |= sd[n];
    return r;
  endfunction

  task automatic chk_err();
    check("multi", err_multi_ack, exp_multi);
    check("ovr", err_overrun, exp_ovr);
    check("tocnt", err_timeout_cnt, exp_cnt[15:0]);
  endtask

  task automatic apply_err(input bit clr, input logic [NS-1:0] m);
    if (clr) begin exp_multi = 0; exp_ovr = 0; exp_cnt = 0; end
    if ($countones(m) > 1) exp_multi = 1;
  endtask

  task automatic rd_txn(input logic [AW-1:0] a, input logic [NS-1:0] m,
                        input int j, input bit clr);
    logic [DW-1:0] e;
    up_rreq = 1; up_raddr = a;
    tick();
    up_rreq = 0;
    check("s_rreq", s_rreq, 1);
    check("s_raddr", s_raddr, a);
    check("busy_rd", busy, 1);
    for (int i = 0; i < j; i++) begin
      tick();
      check("s_rreq_1c", s_rreq, 0);
      check("rack_early", up_rack, 0);
    end
    load_sd();
    e = merge(m);
    s_rack = m; err_clr = clr;
    tick();
    s_rack = '0; err_clr = 0;
    load_sd();
    apply_err(clr, m);
    check("rack", up_rack, 1);
    check("rdata", up_rdata, e);
    chk_err();
    tick();
    check("rack_1c", up_rack, 0);
    check("rdata_0", up_rdata, 0);
    check("busy_end", busy, 0);
  endtask

  task automatic wr_txn(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [NS-1:0] m, input int j, input bit clr);
    up_wreq = 1; up_waddr = a; up_wdata = d;
    tick();
    up_wreq = 0; up_wdata = $urandom;
    check("s_wreq", s_wreq, 1);
    check("s_waddr", s_waddr, a);
    check("s_wdata", s_wdata, d);
    for (int i = 0; i < j; i++) begin
      tick();
      check("s_wreq_1c", s_wreq, 0);
      check("wack_early", up_wack, 0);
    end
    s_wack = m; err_clr = clr;
    tick();
    s_wack = '0; err_clr = 0;
    apply_err(clr, m);
    check("wack", up_wack, 1);
    check("s_wdata_hold", s_wdata, d);
    chk_err();
    tick();
    check("wack_1c", up_wack, 0);
    check("busy_wend", busy, 0);
  endtask

  initial begin
    load_sd();
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_rack", up_rack, 0);
    check("rst_wack", up_wack, 0);
    check("rst_rdata", up_rdata, 0);
    check("rst_saddr", {s_waddr, s_raddr}, 0);
    check("rst_swdata", s_wdata, 0);
    check("rst_sreq", {s_wreq, s_rreq}, 0);
    chk_err();
    reset = 0;
    tick();

    // slave 2 answers two cycles after s_rreq
    sd[2] = 32'h12345678;
    rd_txn(11'h123, 4'b0100, 2, 0);
    wr_txn(11'h040, 32'hA5A5, 4'b0001, 0, 0);

    // slaves 0 and 3 together: OR-merge plus multi-ack
    up_rreq = 1; up_raddr = 11'h7;
    tick(); up_rreq = 0;
    s_rdata = '0;
    s_rdata[0*DW+:DW] = 32'h0F00;
    s_rdata[3*DW+:DW] = 32'h00F0;
    s_rdata[1*DW+:DW] = 32'hFFFF_FFFF;
    s_rack = 4'b1001;
    tick(); s_rack = '0;
    exp_multi = 1;
    check("mrg_rdata", up_rdata, 32'h0FF0);
    chk_err();
    err_clr = 1; tick(); err_clr = 0;
    exp_multi = 0;
    chk_err();

    // spurious acks in IDLE
    load_sd();
    s_rack = 4'b1001; s_wack = 4'b0110;
    tick(); s_rack = '0; s_wack = '0;
    check("spur_rack", up_rack, 0);
    check("spur_wack", up_wack, 0);
    check("spur_busy", busy, 0);
    tick();
    check("spur_rack2", up_rack, 0);
    chk_err();

    // overrun while in WAIT
    up_rreq = 1; up_raddr = 11'h55;
    tick(); up_rreq = 0;
    tick(); up_rreq = 1; up_raddr = 11'h66;
    tick(); up_rreq = 0;
    exp_ovr = 1;
    check("ovr_noreq", s_rreq, 0);
    check("ovr_addr", s_raddr, 11'h55);
    chk_err();
    load_sd();
    s_rack = 4'b0010;
    tick(); s_rack = '0;
    check("ovr_rack", up_rack, 1);
    check("ovr_rdata", up_rdata, sd[1]);
    tick();
    // clear coinciding with a new overrun leaves the flag set
    up_wreq = 1; tick(); up_wreq = 0;
    up_wreq = 1; err_clr = 1; tick(); up_wreq = 0; err_clr = 0;
    exp_ovr = 1;
    chk_err();
    s_wack = 4'b0001; tick(); s_wack = '0;
    check("ovr_wack", up_wack, 1);
    tick();
    err_clr = 1; tick(); err_clr = 0;
    exp_ovr = 0;
    chk_err();

    // reset while waiting aborts silently
    up_rreq = 1; tick(); up_rreq = 0;
    tick();
    reset = 1; tick(); reset = 0;
    check("rstw_busy", busy, 0);
    check("rstw_rack", up_rack, 0);
    s_rack = 4'b0001; tick(); s_rack = '0;
    check("rstw_late", up_rack, 0);
    tick();
    check("rstw_late2", up_rack, 0);
    check("rstw_sreq", s_rreq, 0);

    // simultaneous read and write, acks on different cycles
    load_sd();
    up_wreq = 1; up_waddr = 11'h10; up_wdata = 32'h1;
    up_rreq = 1; up_raddr = 11'h20;
    tick(); up_wreq = 0; up_rreq = 0;
    check("sim_sw", s_wreq, 1);
    check("sim_sr", s_rreq, 1);
    tick();
    s_wack = 4'b0001; tick(); s_wack = '0;
    check("sim_wack", up_wack, 1);
    check("sim_rack0", up_rack, 0);
    s_rack = 4'b0010; tick(); s_rack = '0;
    check("sim_rack", up_rack, 1);
    check("sim_rdata", up_rdata, sd[1]);
    check("sim_wack0", up_wack, 0);
    check("sim_busy1", busy, 1);
    tick();
    check("sim_busy0", busy, 0);

`ifdef UP_BUS_TIMEOUT_EN
    // no ack: timeout response TO cycles after WAIT entry
    up_rreq = 1; tick(); up_rreq = 0;
    for (int i = 1; i < TO; i++) begin
      tick();
      check("to_early", up_rack, 0);
    end
    tick();
    exp_cnt++;
    check("to_rack", up_rack, 1);
    check("to_rdata", up_rdata, 32'hDEADDEAD);
    chk_err();
    s_rack = 4'b0001; tick(); s_rack = '0;
    check("to_late", up_rack, 0);
    tick();
    check("to_late2", up_rack, 0);
    // ack exactly in the last WAIT cycle wins
    load_sd();
    up_rreq = 1; tick(); up_rreq = 0;
    for (int i = 1; i < TO; i++) tick();
    s_rack = 4'b0100; tick(); s_rack = '0;
    check("to_edge_rack", up_rack, 1);
    check("to_edge_rdata", up_rdata, sd[2]);
    chk_err();
    tick();
    // both directions time out together
    up_rreq = 1; up_wreq = 1; tick(); up_rreq = 0; up_wreq = 0;
    for (int i = 1; i <= TO; i++) tick();
    exp_cnt += 2;
    check("to2_acks", {up_wack, up_rack}, 2'b11);
    chk_err();
    tick();
`else
    // WAIT holds indefinitely without an ack
    up_rreq = 1; tick(); up_rreq = 0;
    for (int i = 0; i < 100; i++) tick();
    check("hold_busy", busy, 1);
    check("hold_rack", up_rack, 0);
    load_sd();
    s_rack = 4'b1000; tick(); s_rack = '0;
    check("hold_rdata", up_rdata, sd[3]);
    chk_err();
    tick();
`endif

    for (int k = 0; k < 40; k++) begin
      logic [NS-1:0] m;
      m = NS'($urandom_range(1, (1 << NS) - 1));
      if ($urandom_range(0, 1) == 1)
        rd_txn(AW'($urandom), m, $urandom_range(0, 4),
               $urandom_range(0, 5) == 0);
      else
        wr_txn(AW'($urandom), $urandom, m, $urandom_range(0, 4),
               $urandom_range(0, 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
